// File: rtl/quad_dec_pkg.sv
// Shared definitions for the quadrature decoder.
//  - Phase encodings {A,B} in the order visited when moving up: 00 -> 10 -> 11 -> 01 -> 00.
//  - Direction encodings for the dir output.
//  - Transition class produced by comparing the previous and current phase.
//  - classify(): maps (prev, cur) onto a transition class.
package quad_dec_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {TR_NONE, TR_UP, TR_DN, TR_ILLEGAL} trans_e;

    // Phase that follows ph when the encoder moves up (A leads B).
    function automatic logic [1:0] next_up(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_e tr;
        if (cur == prev) begin
            tr = TR_NONE;
        end else if (cur == next_up(prev)) begin
            tr = TR_UP;
        end else if (prev == next_up(cur)) begin
            tr = TR_DN;
        end else begin
            tr = TR_ILLEGAL;  // both bits flipped in one sample
        end
        return tr;
    endfunction

endpackage

// File: rtl/quad_input_cond.sv
// One encoder channel: multi-flop synchroniser, optionally followed by a glitch filter.
// Configuration macro: QDEC_GLITCH_FILTER_EN enables the filter stage.
// Ports:
//  clk      in   system clock
//  reset_n  in   asynchronous active-low reset
//  raw_i    in   asynchronous pad input
//  cond_o   out  synchronised (and, with the filter, debounced) channel value
module quad_input_cond #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic cond_o
);
    import quad_dec_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned RunW = $clog2(FILTER_LEN);

    logic            sample;
    logic [RunW-1:0] run_q, run_d;
    logic            filt_q, filt_d;

    assign sample = sync_q[SYNC_STAGES-1];

    // run_q counts consecutive samples that disagree with the filtered value; the
    // filtered value follows only once FILTER_LEN such samples have been seen in a row.
    always_comb begin
        run_d  = run_q;
        filt_d = filt_q;
        if (sample == filt_q) begin
            run_d = '0;
        end else if (run_q == RunW'(FILTER_LEN - 1)) begin
            filt_d = sample;
            run_d  = '0;
        end else begin
            run_d = run_q + RunW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            filt_q <= filt_d;
        end
    end

    assign cond_o = filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN != 0);
    assign cond_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: turns A/B channels into step/dir strobes and a modulo position
// count, and flags illegal (both-bit) phase jumps with a sticky error.
// Configuration macro: QDEC_GLITCH_FILTER_EN adds a FILTER_LEN-sample glitch filter per channel.
// Ports:
//  clk      in   system clock (rising edge)
//  reset_n  in   asynchronous active-low reset
//  enable   in   1: decode and count; 0: track phase only
//  clear    in   synchronous clear of count (overrides a same-cycle step)
//  err_clr  in   synchronous clear of err (a same-cycle illegal change wins)
//  quad_a   in   encoder channel A (asynchronous)
//  quad_b   in   encoder channel B (asynchronous)
//  step     out  one-cycle pulse per legal transition
//  dir      out  direction of last legal step (1 up, 0 down)
//  count    out  position count, modulo 2^CNT_WIDTH
//  wrap     out  one-cycle pulse when count crosses MAX<->0
//  err      out  sticky illegal-transition flag
module quadrature_decoder #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 err_clr,
    input  logic                 quad_a,
    input  logic                 quad_b,
    output logic                 step,
    output logic                 dir,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 wrap,
    output logic                 err
);
    import quad_dec_pkg::*;

    // Cycles after reset before the conditioned phase reflects the pads. prev_phase is
    // reloaded during this window so the reset-zero pipeline never looks like a transition.
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned PrimeCycles = SYNC_STAGES + FILTER_LEN + 1;
`else
    localparam int unsigned PrimeCycles = SYNC_STAGES + 1;
`endif
    localparam int unsigned PrimeW = $clog2(PrimeCycles + 1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic       a_s, b_s;
    logic [1:0] phase;
    trans_e     tr;
    logic       primed;

    logic [1:0]           prev_phase_q, prev_phase_d;
    logic [PrimeW-1:0]    prime_cnt_q, prime_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;

    quad_input_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_cond_a (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (quad_a),
        .cond_o  (a_s)
    );

    quad_input_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_cond_b (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (quad_b),
        .cond_o  (b_s)
    );

    assign phase  = {a_s, b_s};
    assign tr     = classify(prev_phase_q, phase);
    assign primed = (prime_cnt_q == PrimeW'(PrimeCycles));

    always_comb begin
        prev_phase_d = phase;  // tracked every cycle, also while disabled
        prime_cnt_d  = primed ? prime_cnt_q : prime_cnt_q + PrimeW'(1);
        count_d      = count_q;
        step_d       = 1'b0;
        dir_d        = dir_q;
        wrap_d       = 1'b0;
        err_d        = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        if (primed && enable) begin
            case (tr)
                TR_UP: begin
                    step_d  = 1'b1;
                    dir_d   = DIR_UP;
                    count_d = count_q + CNT_WIDTH'(1);
                    wrap_d  = (count_q == CntMax);
                end
                TR_DN: begin
                    step_d  = 1'b1;
                    dir_d   = DIR_DN;
                    count_d = count_q - CNT_WIDTH'(1);
                    wrap_d  = (count_q == '0);
                end
                TR_ILLEGAL: begin
                    err_d = 1'b1;  // set wins over a simultaneous err_clr
                end
                default: ;
            endcase
        end

        if (clear) begin
            count_d = '0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_phase_q <= PH_00;
            prime_cnt_q  <= '0;
            count_q      <= '0;
            step_q       <= 1'b0;
            dir_q        <= DIR_UP;
            wrap_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_phase_q <= prev_phase_d;
            prime_cnt_q  <= prime_cnt_d;
            count_q      <= count_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            wrap_q       <= wrap_d;
            err_q        <= err_d;
        end
    end

    assign step  = step_q;
    assign dir   = dir_q;
    assign count = count_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed scenarios plus randomized traffic,
// checked every cycle against a position-arithmetic reference model.
module tb_quadrature_decoder;

    localparam int unsigned CNT_WIDTH   = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 4;
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned LAT = SYNC_STAGES + FILTER_LEN + 1;
`else
    localparam int unsigned LAT = SYNC_STAGES + 1;
`endif
    localparam int unsigned MOD = 1 << CNT_WIDTH;
    localparam logic [CNT_WIDTH+3:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 1'b0, {CNT_WIDTH{1'b0}}};

    logic                 clk;
    logic                 reset_n;
    logic                 enable;
    logic                 clear;
    logic                 err_clr;
    logic                 quad_a;
    logic                 quad_b;
    logic                 step;
    logic                 dir;
    logic [CNT_WIDTH-1:0] count;
    logic                 wrap;
    logic                 err;

    int n_vec = 0;
    int n_err = 0;
    int cur_pos = 0;

    logic [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quadrature_decoder #(
        .CNT_WIDTH   (CNT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (clear),
        .err_clr (err_clr),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .step    (step),
        .dir     (dir),
        .count   (count),
        .wrap    (wrap),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Position of a phase along the up sequence; a move is the difference of positions mod 4.
    function automatic int gray_pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    logic [1:0]  m_raw [64];     // pad samples, indexed by edge number since reset
    int unsigned m_edges;
    logic [1:0]  m_prev;
    logic [1:0]  m_filt;
    int          m_run [2];
    bit          m_step, m_dir, m_wrap, m_err;
    int unsigned m_count;
    logic [1:0]  m_raw_ph, m_dec_ph;
    int          m_delta;

    always_comb begin
        m_raw_ph = (m_edges >= SYNC_STAGES) ? m_raw[(m_edges - SYNC_STAGES) % 64] : 2'b00;
`ifdef QDEC_GLITCH_FILTER_EN
        m_dec_ph = m_filt;
`else
        m_dec_ph = m_raw_ph;
`endif
        m_delta = (gray_pos(m_dec_ph) - gray_pos(m_prev)) & 3;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_edges <= 0;
            m_prev  <= 2'b00;
            m_filt  <= 2'b00;
            m_run   <= '{0, 0};
            m_step  <= 1'b0;
            m_dir   <= 1'b1;
            m_wrap  <= 1'b0;
            m_err   <= 1'b0;
            m_count <= 0;
        end else begin
            m_raw[m_edges % 64] <= {quad_a, quad_b};
            m_edges <= m_edges + 1;
            m_prev  <= m_dec_ph;
            m_step  <= 1'b0;
            m_wrap  <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                if (m_raw_ph[c] == m_filt[c]) begin
                    m_run[c] <= 0;
                end else if (m_run[c] + 1 >= FILTER_LEN) begin
                    m_filt[c] <= m_raw_ph[c];
                    m_run[c]  <= 0;
                end else begin
                    m_run[c] <= m_run[c] + 1;
                end
            end
            if (err_clr) m_err <= 1'b0;
            if (m_edges >= LAT && enable) begin
                if (m_delta == 1) begin
                    m_step <= 1'b1;
                    m_dir  <= 1'b1;
                    if (!clear) begin
                        m_count <= (m_count + 1) % MOD;
                        m_wrap  <= (m_count == MOD - 1);
                    end
                end else if (m_delta == 3) begin
                    m_step <= 1'b1;
                    m_dir  <= 1'b0;
                    if (!clear) begin
                        m_count <= (m_count + MOD - 1) % MOD;
                        m_wrap  <= (m_count == 0);
                    end
                end else if (m_delta == 2) begin
                    m_err <= 1'b1;
                end
            end
            if (clear) m_count <= 0;
        end
    end

    wire [CNT_WIDTH+3:0] dut_vec = {step, dir, wrap, err, count};
    wire [CNT_WIDTH+3:0] mdl_vec = {m_step, m_dir, m_wrap, m_err, m_count[CNT_WIDTH-1:0]};

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_pos(input int p);
        cur_pos = p & 3;
        quad_a  = up_seq[cur_pos][1];
        quad_b  = up_seq[cur_pos][0];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        enable  = 1'b1;
        clear   = 1'b0;
        err_clr = 1'b0;
        set_pos(2);  // A/B = 11 across reset release
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (dut_vec !== RESET_VEC) begin
            n_err++;
            $display("FAIL reset_values dut=%h want=%h", dut_vec, RESET_VEC);
        end
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_vec++;
            if (step !== 1'b0 || err !== 1'b0 || count !== '0 || dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL reset_hold dut=%h model=%h (step/err/count must be 0)",
                         dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_up_steps();
        int lat;
        int steps;
        steps = 0;
        for (int s = 0; s < 8; s++) begin
            set_pos(cur_pos + 1);
            lat = -1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                n_vec++;
                if (dut_vec !== mdl_vec) begin
                    n_err++;
                    $display("FAIL up_model dut=%h model=%h", dut_vec, mdl_vec);
                end
                if (step === 1'b1) begin
                    steps++;
                    if (lat < 0) lat = k;
                end
            end
            n_vec++;
            if (lat != int'(LAT)) begin
                n_err++;
                $display("FAIL up_latency got=%0d want=%0d", lat, LAT);
            end
        end
        n_vec++;
        if (steps != 8 || count !== CNT_WIDTH'(8) || dir !== 1'b1) begin
            n_err++;
            $display("FAIL up_total steps=%0d count=%0d dir=%b want 8/8/1", steps, count, dir);
        end
    endtask

    task automatic test_wrap();
        int wraps;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_vec++;
        if (count !== '0 || dut_vec !== mdl_vec) begin
            n_err++;
            $display("FAIL wrap_clear count=%0d want=0", count);
        end
        wraps = 0;
        set_pos(cur_pos - 1);
        repeat (8) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL wrap_dn_model dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (wrap === 1'b1) wraps++;
        end
        n_vec++;
        if (count !== '1 || dir !== 1'b0 || wraps != 1) begin
            n_err++;
            $display("FAIL wrap_down count=%h dir=%b wraps=%0d want %h/0/1",
                     count, dir, wraps, MOD - 1);
        end
        wraps = 0;
        set_pos(cur_pos + 1);
        repeat (8) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL wrap_up_model dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (wrap === 1'b1) wraps++;
        end
        n_vec++;
        if (count !== '0 || dir !== 1'b1 || wraps != 1) begin
            n_err++;
            $display("FAIL wrap_up count=%h dir=%b wraps=%0d want 0/1/1", count, dir, wraps);
        end
    endtask

    task automatic test_illegal();
        logic [CNT_WIDTH-1:0] c0;
        int steps;
        while (cur_pos != 0) begin
            set_pos(cur_pos + 1);
            repeat (8) begin
                @(negedge clk);
                n_vec++;
                if (dut_vec !== mdl_vec) begin
                    n_err++;
                    $display("FAIL ill_walk dut=%h model=%h", dut_vec, mdl_vec);
                end
            end
        end
        c0 = m_count[CNT_WIDTH-1:0];
        steps = 0;
        set_pos(2);  // 00 -> 11
        repeat (8) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL ill_model dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (step === 1'b1) steps++;
        end
        n_vec++;
        if (err !== 1'b1 || count !== c0 || steps != 0) begin
            n_err++;
            $display("FAIL ill_jump err=%b count=%0d steps=%0d want 1/%0d/0", err, count, steps, c0);
        end
        set_pos(1);  // legal 11 -> 10
        repeat (8) @(negedge clk);
        set_pos(3);  // 10 -> 01 with err_clr held across the decode cycle
        err_clr = 1'b1;
        repeat (LAT) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL ill_clr_model dut=%h model=%h", dut_vec, mdl_vec);
            end
        end
        err_clr = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL ill_set_wins err=%b want=1", err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL ill_err_clr err=%b want=0", err);
        end
    endtask

    task automatic test_enable();
        logic [CNT_WIDTH-1:0] c0;
        int steps;
        c0 = m_count[CNT_WIDTH-1:0];
        steps = 0;
        enable = 1'b0;
        repeat (4) begin
            set_pos(cur_pos + 1);
            repeat (8) begin
                @(negedge clk);
                n_vec++;
                if (dut_vec !== mdl_vec) begin
                    n_err++;
                    $display("FAIL en_off_model dut=%h model=%h", dut_vec, mdl_vec);
                end
                if (step === 1'b1) steps++;
            end
        end
        enable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (step === 1'b1) steps++;
        end
        n_vec++;
        if (steps != 0 || count !== c0) begin
            n_err++;
            $display("FAIL en_hold steps=%0d count=%0d want 0/%0d", steps, count, c0);
        end
        set_pos(cur_pos + 1);
        repeat (8) begin
            @(negedge clk);
            if (step === 1'b1) steps++;
        end
        n_vec++;
        if (steps != 1 || count !== c0 + CNT_WIDTH'(1)) begin
            n_err++;
            $display("FAIL en_resume steps=%0d count=%0d want 1/%0d", steps, count, c0 + 1);
        end
    endtask

    task automatic test_clear_step();
        set_pos(cur_pos + 1);
        repeat (LAT - 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_vec++;
        if (step !== 1'b1 || count !== '0 || wrap !== 1'b0 || dir !== 1'b1) begin
            n_err++;
            $display("FAIL clear_step step=%b count=%0d wrap=%b dir=%b want 1/0/0/1",
                     step, count, wrap, dir);
        end
        repeat (4) @(negedge clk);
    endtask

`ifdef QDEC_GLITCH_FILTER_EN
    task automatic test_glitch();
        int d;
        int steps;
        int lat;
        d = (cur_pos % 2 == 0) ? 1 : -1;  // neighbour that differs on channel A
        steps = 0;
        set_pos(cur_pos + d);
        repeat (3) @(negedge clk);
        set_pos(cur_pos - d);
        repeat (20) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL glitch_model dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (step === 1'b1) steps++;
        end
        n_vec++;
        if (steps != 0) begin
            n_err++;
            $display("FAIL glitch_short steps=%0d want=0", steps);
        end
        lat = -1;
        set_pos(cur_pos + d);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                steps++;
                if (lat < 0) lat = k;
            end
        end
        n_vec++;
        if (steps != 1 || lat != int'(LAT)) begin
            n_err++;
            $display("FAIL glitch_stable steps=%0d lat=%0d want 1/%0d", steps, lat, LAT);
        end
    endtask
`endif

    task automatic test_random();
        int r;
        repeat (300) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      set_pos(cur_pos + 1);
            else if (r < 80) set_pos(cur_pos - 1);
            else if (r < 88) set_pos(cur_pos + 2);
            enable  = ($urandom_range(0, 9) != 0);
            clear   = ($urandom_range(0, 19) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                n_vec++;
                if (dut_vec !== mdl_vec) begin
                    n_err++;
                    $display("FAIL random dut=%h model=%h t=%0t", dut_vec, mdl_vec, $time);
                end
            end
        end
        enable  = 1'b1;
        clear   = 1'b0;
        err_clr = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        repeat (3) begin
            set_pos(cur_pos + 1);
            repeat (2) @(negedge clk);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (dut_vec !== RESET_VEC) begin
            n_err++;
            $display("FAIL mid_reset dut=%h want=%h", dut_vec, RESET_VEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            n_vec++;
            if (dut_vec !== mdl_vec || step !== 1'b0 || err !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reprime dut=%h model=%h", dut_vec, mdl_vec);
            end
        end
        set_pos(cur_pos + 1);
        repeat (12) @(negedge clk);
        n_vec++;
        if (count !== CNT_WIDTH'(1) || dut_vec !== mdl_vec) begin
            n_err++;
            $display("FAIL mid_first_step count=%0d want=1", count);
        end
    endtask

    initial begin
        test_reset();
        test_up_steps();
        test_wrap();
        test_illegal();
        test_enable();
        test_clear_step();
`ifdef QDEC_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
